// File: rtl/mio_bridge.sv
// mio_bridge: data-side memory/IO bridge between the CPU core and RAM plus
// its peripherals (LED/switch port, buffered UART TX FIFO, compare timer).
// Optional feature macro: MIO_TIMER_EN adds the COUNT/CMP/CTRL timer and irq.
// When MIO_TIMER_EN is undefined, the timer registers read 0, writes to them
// are ignored, STATUS[16] reads 0 and irq is tied low.
module mio_bridge #(
   parameter int RAM_AW     = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_wea,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_wea,
   input  logic [31:0]       ram_rdata,
   input  logic [15:0]       sw,
   output logic [15:0]       led,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [31:0] A_LED    = 32'hE000_0000;
   localparam logic [31:0] A_SW     = 32'hF000_0000;
   localparam logic [31:0] A_TXDATA = 32'hF000_0004;
   localparam logic [31:0] A_STATUS = 32'hF000_0008;
   localparam logic [31:0] A_COUNT  = 32'hF000_000C;
   localparam logic [31:0] A_CMP    = 32'hF000_0010;
   localparam logic [31:0] A_CTRL   = 32'hF000_0014;

   // Byte offset within the word never affects decode.
   logic [31:0] waddr;
   logic        unused_addr_lsb;
   assign waddr           = {cpu_addr[31:2], 2'b00};
   assign unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

   logic wr, sel_ram, sel_led, sel_sw, sel_tx, sel_status;
   assign wr         = |cpu_wea;
   assign sel_ram    = (cpu_addr[31:RAM_AW+2] == '0);
   assign sel_led    = (waddr == A_LED);
   assign sel_sw     = (waddr == A_SW);
   assign sel_tx     = (waddr == A_TXDATA);
   assign sel_status = (waddr == A_STATUS);

   assign ram_addr  = cpu_addr[RAM_AW+1:2];
   assign ram_wdata = cpu_wdata;
   assign ram_wea   = sel_ram ? cpu_wea : 4'b0000;

   // ---------------- TX FIFO ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt;
   logic          full, pop, push_req, push_ok, push_rej, overflow;

   assign full     = (cnt == CW'(FIFO_DEPTH));
   assign tx_valid = (cnt != '0);
   assign tx_data  = mem[rd_ptr];
   assign pop      = tx_valid & tx_ready;
   assign push_req = sel_tx & cpu_wea[0];
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push_ok  = push_req & (~full | pop);
   assign push_rej = push_req & ~push_ok;
   assign cpu_ready = ~push_rej;

   // FIFO storage; cleared on reset so the head byte reads 0 afterwards
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[wr_ptr] <= cpu_wdata[7:0];
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + CW'(push_ok) - CW'(pop);
      end
   end

   // Sticky overflow flag: set by a dropped push, cleared via STATUS bit 2
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   overflow <= 1'b0;
      else if (push_rej)                           overflow <= 1'b1;
      else if (sel_status && wr && cpu_wdata[2])   overflow <= 1'b0;
   end

   // LED register, only the low two byte lanes exist
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led <= '0;
      end else if (sel_led) begin
         if (cpu_wea[0]) led[7:0]  <= cpu_wdata[7:0];
         if (cpu_wea[1]) led[15:8] <= cpu_wdata[15:8];
      end
   end

   // ---------------- compare timer ----------------
   logic        pending;
   logic [31:0] tmr_rdata;
   logic        tmr_hit;

`ifdef MIO_TIMER_EN
   logic [31:0] tmr_cnt, tmr_cmp;
   logic [1:0]  ctrl;
   logic        sel_count, sel_cmp, sel_ctrl;

   assign sel_count = (waddr == A_COUNT);
   assign sel_cmp   = (waddr == A_CMP);
   assign sel_ctrl  = (waddr == A_CTRL);
   assign tmr_hit   = sel_count | sel_cmp | sel_ctrl;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   // Counter: a CPU write takes priority over the free-running increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 tmr_cnt <= '0;
      else if (sel_count && wr)  tmr_cnt <= lane_merge(tmr_cnt, cpu_wdata, cpu_wea);
      else if (ctrl[0])          tmr_cnt <= tmr_cnt + 32'd1;
   end

   // Compare value and control bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr_cmp <= 32'hFFFF_FFFF;
         ctrl    <= 2'b00;
      end else begin
         if (sel_cmp && wr)          tmr_cmp <= lane_merge(tmr_cmp, cpu_wdata, cpu_wea);
         if (sel_ctrl && cpu_wea[0]) ctrl    <= cpu_wdata[1:0];
      end
   end

   // Sticky match flag; a new match beats a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= 1'b0;
      else       pending <= (ctrl[0] && (tmr_cnt == tmr_cmp)) |
                            (pending & ~(sel_status & wr & cpu_wdata[16]));
   end

   assign irq = pending & ctrl[1];

   // Timer register read mux
   always_comb begin
      tmr_rdata = '0;
      if (sel_count)     tmr_rdata = tmr_cnt;
      else if (sel_cmp)  tmr_rdata = tmr_cmp;
      else if (sel_ctrl) tmr_rdata = {30'b0, ctrl};
   end
`else
   assign pending   = 1'b0;
   assign irq       = 1'b0;
   assign tmr_hit   = 1'b0;
   assign tmr_rdata = '0;
`endif

   // Combinational read mux; unmapped addresses read 0
   always_comb begin
      cpu_rdata = '0;
      if (sel_ram)          cpu_rdata = ram_rdata;
      else if (sel_led)     cpu_rdata = {16'b0, led};
      else if (sel_sw)      cpu_rdata = {16'b0, sw};
      else if (sel_status)  cpu_rdata = {15'b0, pending, 8'(cnt), 5'b0,
                                         overflow, full, ~tx_valid};
      else if (tmr_hit)     cpu_rdata = tmr_rdata;
   end

endmodule
